// File: rtl/and_gate_reg_if.sv
// Operand/result bundle for and_gate_reg: the master drives en/a/b, the slave returns
// the registered result, its flags and the optional capture counter.
interface and_gate_reg_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
);
  logic             en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] y;
  logic             y_all;
  logic             y_zero;
  logic             vld;
  logic [CNT_W-1:0] match_cnt;

  modport master (output en, a, b, input y, y_all, y_zero, vld, match_cnt);
  modport slave  (input en, a, b, output y, y_all, y_zero, vld, match_cnt);
endinterface

// File: rtl/and_gate_reg.sv
// Registered bitwise AND with all-ones / all-zeros flags and a capture-valid strobe.
// Define AND_GATE_COUNT_EN to build a saturating counter of all-ones captures.
module and_gate_reg #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  and_gate_reg_if.slave bus
);
  logic [WIDTH-1:0] and_d;
  logic [WIDTH-1:0] y_q;
  logic             y_all_q;
  logic             y_zero_q;
  logic             vld_q;

  // Each result bit sees only its own operand pair.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign and_d[i] = bus.a[i] & bus.b[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q      <= '0;
      y_all_q  <= 1'b0;
      y_zero_q <= 1'b1;
      vld_q    <= 1'b0;
    end else begin
      vld_q <= bus.en;
      if (bus.en) begin
        y_q      <= and_d;
        y_all_q  <= &and_d;
        y_zero_q <= ~|and_d;
      end
    end
  end

  assign bus.y      = y_q;
  assign bus.y_all  = y_all_q;
  assign bus.y_zero = y_zero_q;
  assign bus.vld    = vld_q;

`ifdef AND_GATE_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturates at all-ones rather than wrapping; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (bus.en && (&and_d) && (cnt_q != {CNT_W{1'b1}}))
      cnt_q <= cnt_q + 1'b1;
  end

  assign bus.match_cnt = cnt_q;
`else
  assign bus.match_cnt = '0;
`endif
endmodule

// File: tb/tb_and_gate_reg.sv
// Directed bench for and_gate_reg: a WIDTH=1/CNT_W=4 instance and a WIDTH=8 instance.
module tb_and_gate_reg;
`ifdef AND_GATE_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errs = 0;
  int   checks = 0;

  and_gate_reg_if #(.WIDTH(1), .CNT_W(4))  if1 ();
  and_gate_reg_if #(.WIDTH(8), .CNT_W(16)) if8 ();

  and_gate_reg #(.WIDTH(1), .CNT_W(4))  u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  and_gate_reg #(.WIDTH(8), .CNT_W(16)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] pat [4];
  logic       exp_y [4];

  initial begin
    pat[0] = 2'b00; pat[1] = 2'b10; pat[2] = 2'b01; pat[3] = 2'b11;
    exp_y[0] = 1'b0; exp_y[1] = 1'b0; exp_y[2] = 1'b0; exp_y[3] = 1'b1;
    if1.en = 1'b0; if1.a = 1'b0; if1.b = 1'b0;
    if8.en = 1'b0; if8.a = 8'h00; if8.b = 8'h00;

    // 1: reset, then release with en=0
    #12;
    chk("rst_y", 64'(if1.y), 64'd0);
    chk("rst_zero", 64'(if1.y_zero), 64'd1);
    chk("rst_cnt", 64'(if1.match_cnt), 64'd0);
    rst_n = 1'b1;
    tick(); tick();
    chk("idle_y", 64'(if1.y), 64'd0);
    chk("idle_all", 64'(if1.y_all), 64'd0);
    chk("idle_zero", 64'(if1.y_zero), 64'd1);
    chk("idle_vld", 64'(if1.vld), 64'd0);
    chk("idle_y8", 64'(if8.y), 64'd0);

    // 2: truth table, back-to-back captures
    if1.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      {if1.a, if1.b} = pat[i];
      tick();
      chk($sformatf("tt_y%0d", i), 64'(if1.y), 64'(exp_y[i]));
      chk($sformatf("tt_vld%0d", i), 64'(if1.vld), 64'd1);
      chk($sformatf("tt_zero%0d", i), 64'(if1.y_zero), 64'(!exp_y[i]));
    end
    chk("tt_all", 64'(if1.y_all), 64'd1);
    chk("tt_cnt1", 64'(if1.match_cnt), CNT_EN ? 64'd1 : 64'd0);

    // 3: hold with en=0
    if1.en = 1'b0; if1.a = 1'b0; if1.b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("hold_y%0d", i), 64'(if1.y), 64'd1);
      chk($sformatf("hold_vld%0d", i), 64'(if1.vld), 64'd0);
    end
    chk("hold_all", 64'(if1.y_all), 64'd1);

    // 4: WIDTH=8 mixed, all-ones, all-zeros
    if8.en = 1'b1; if8.a = 8'hF0; if8.b = 8'h3C;
    tick();
    chk("w8_y", 64'(if8.y), 64'h30);
    chk("w8_all", 64'(if8.y_all), 64'd0);
    chk("w8_zero", 64'(if8.y_zero), 64'd0);
    chk("w8_vld", 64'(if8.vld), 64'd1);
    if8.a = 8'hFF; if8.b = 8'hFF;
    tick();
    chk("w8_ff_y", 64'(if8.y), 64'hFF);
    chk("w8_ff_all", 64'(if8.y_all), 64'd1);
    chk("w8_ff_zero", 64'(if8.y_zero), 64'd0);
    if8.a = 8'hAA; if8.b = 8'h55;
    tick();
    chk("w8_00_y", 64'(if8.y), 64'h00);
    chk("w8_00_all", 64'(if8.y_all), 64'd0);
    chk("w8_00_zero", 64'(if8.y_zero), 64'd1);
    if8.a = 8'h81; if8.b = 8'hC1;
    tick();
    chk("w8_81_y", 64'(if8.y), 64'h81);
    if8.en = 1'b0;
    tick();
    chk("w8_hold_y", 64'(if8.y), 64'h81);
    chk("w8_hold_vld", 64'(if8.vld), 64'd0);

    // 5: async reset between edges while y=1
    if1.en = 1'b1; if1.a = 1'b1; if1.b = 1'b1;
    tick();
    chk("pre_rst_y", 64'(if1.y), 64'd1);
    chk("pre_rst_vld", 64'(if1.vld), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_y", 64'(if1.y), 64'd0);
    chk("arst_vld", 64'(if1.vld), 64'd0);
    chk("arst_zero", 64'(if1.y_zero), 64'd1);
    chk("arst_cnt", 64'(if1.match_cnt), 64'd0);
    chk("arst_y8", 64'(if8.y), 64'd0);
    if1.en = 1'b0;
    @(negedge clk);
    chk("arst_hold_y", 64'(if1.y), 64'd0);
    rst_n = 1'b1;

    // 6: saturating match counter (CNT_W=4)
    if1.en = 1'b1; if1.a = 1'b1; if1.b = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 3) chk("cnt3", 64'(if1.match_cnt), CNT_EN ? 64'd3 : 64'd0);
      if (i == 15) chk("cnt15", 64'(if1.match_cnt), CNT_EN ? 64'd15 : 64'd0);
    end
    chk("cnt_sat", 64'(if1.match_cnt), CNT_EN ? 64'd15 : 64'd0);
    if1.a = 1'b0;
    tick();
    chk("cnt_a0", 64'(if1.match_cnt), CNT_EN ? 64'd15 : 64'd0);
    chk("cnt_a0_y", 64'(if1.y), 64'd0);
    if1.en = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
